// File: rtl/downscale_bilinear_stream.sv
// downscale_bilinear_stream: Q8.8 bilinear downscaler from a 1-cycle-latency frame memory to a valid/ready pixel stream.
// Ports: clk, rst_n (synchronous, active-low).
//   start, cfg_dst_w/h, cfg_x/y_ratio : frame launch and configuration, latched when start is accepted in IDLE.
//   mem_rd_en, mem_addr, mem_rd_data : frame memory read port, data returns one cycle after the strobe.
//   out_valid, out_ready, out_data, out_x, out_y, out_last : destination pixel stream in raster order.
//   busy, done, cfg_err : frame in progress, end-of-frame pulse, rejected-start pulse.
module downscale_bilinear_stream #(
    parameter int SRC_W  = 640,
    parameter int SRC_H  = 480,
    parameter int PIX_W  = 8,
    parameter int DIM_W  = $clog2((SRC_W > SRC_H) ? SRC_W : SRC_H) + 1,
    parameter int ADDR_W = $clog2(SRC_W * SRC_H)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DIM_W-1:0]  cfg_dst_w,
    input  logic [DIM_W-1:0]  cfg_dst_h,
    input  logic [15:0]       cfg_x_ratio,
    input  logic [15:0]       cfg_y_ratio,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [PIX_W-1:0]  mem_rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PIX_W-1:0]  out_data,
    output logic [DIM_W-1:0]  out_x,
    output logic [DIM_W-1:0]  out_y,
    output logic              out_last,
    output logic              busy,
    output logic              done,
    output logic              cfg_err
);
    localparam int TW = PIX_W + 9;
    localparam int SW = PIX_W + 18;
    localparam logic [DIM_W-1:0] XMAX = DIM_W'(SRC_W - 1);
    localparam logic [DIM_W-1:0] YMAX = DIM_W'(SRC_H - 1);
    localparam logic [PIX_W-1:0] PMAX = '1;

    typedef enum logic [2:0] {IDLE, FETCH, CALC, OUT, DONE} state_t;
    state_t state, nxt;

    logic [DIM_W-1:0] dst_w, dst_h, i, j;
    logic [15:0]      x_ratio, y_ratio;
    logic [2:0]       fcnt;
    logic [PIX_W-1:0] p00, p10, p01, p11;
    logic             cfg_ok, accept, hs, row_end;

    assign cfg_ok  = cfg_dst_w != '0 && cfg_dst_h != '0 &&
                     cfg_dst_w <= DIM_W'(SRC_W) && cfg_dst_h <= DIM_W'(SRC_H);
    assign accept  = state == IDLE && start && cfg_ok;
    assign hs      = state == OUT && out_ready;
    assign row_end = j == dst_w - DIM_W'(1);

    // Source coordinates of the current destination pixel; j and i only
    // move on the output handshake, so these stay valid through CALC.
    logic [31:0]      x_fp, y_fp;
    logic             x_cl, y_cl;
    logic [DIM_W-1:0] x_l, x_h, y_l, y_h, rd_x, rd_y;
    logic [7:0]       alpha, beta;

    assign x_fp  = 32'(j) * 32'(x_ratio);
    assign y_fp  = 32'(i) * 32'(y_ratio);
    assign x_cl  = x_fp[31:8] >= 24'(SRC_W - 1);
    assign y_cl  = y_fp[31:8] >= 24'(SRC_H - 1);
    assign x_l   = x_cl ? XMAX : x_fp[8 +: DIM_W];
    assign y_l   = y_cl ? YMAX : y_fp[8 +: DIM_W];
    assign alpha = x_cl ? 8'd0 : x_fp[7:0];
    assign beta  = y_cl ? 8'd0 : y_fp[7:0];
    assign x_h   = (x_l == XMAX) ? x_l : x_l + DIM_W'(1);
    assign y_h   = (y_l == YMAX) ? y_l : y_l + DIM_W'(1);

    // Read order I00, I10, I01, I11: bit 0 of the slot picks the high x,
    // bit 1 picks the high y.
    assign rd_x = fcnt[0] ? x_h : x_l;
    assign rd_y = fcnt[1] ? y_h : y_l;

    // Bilinear blend; weights per axis sum to 256, so sum fits PIX_W+16 bits
    // and the extra headroom only guards the rounding add.
    logic [8:0]       wa, wb;
    logic [TW-1:0]    top, bot;
    logic [SW-1:0]    sum, rnd;
    logic [PIX_W-1:0] pix;

    assign wa  = 9'd256 - {1'b0, alpha};
    assign wb  = 9'd256 - {1'b0, beta};
    assign top = TW'(p00) * TW'(wa) + TW'(p10) * TW'(alpha);
    assign bot = TW'(p01) * TW'(wa) + TW'(p11) * TW'(alpha);
    assign sum = SW'(top) * SW'(wb) + SW'(bot) * SW'(beta);
    assign rnd = (sum + SW'(32768)) >> 16;
    assign pix = (rnd > SW'(PMAX)) ? PMAX : rnd[PIX_W-1:0];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= nxt;
        end
    end

    always_comb begin
        nxt       = state;
        mem_rd_en = 1'b0;
        mem_addr  = '0;
        out_valid = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE:    nxt = accept ? FETCH : IDLE;
            FETCH:   nxt = (fcnt == 3'd4) ? CALC : FETCH;
            CALC:    nxt = OUT;
            OUT:     nxt = hs ? (out_last ? DONE : FETCH) : OUT;
            DONE:    nxt = IDLE;
            default: nxt = IDLE;
        endcase
        mem_rd_en = state == FETCH && fcnt != 3'd4;
        mem_addr  = mem_rd_en ? ADDR_W'(rd_y) * ADDR_W'(SRC_W) + ADDR_W'(rd_x) : '0;
        out_valid = state == OUT;
        busy      = state != IDLE;
        done      = state == DONE;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dst_w    <= '0;
            dst_h    <= '0;
            x_ratio  <= '0;
            y_ratio  <= '0;
            i        <= '0;
            j        <= '0;
            fcnt     <= '0;
            p00      <= '0;
            p10      <= '0;
            p01      <= '0;
            p11      <= '0;
            out_data <= '0;
            out_x    <= '0;
            out_y    <= '0;
            out_last <= 1'b0;
            cfg_err  <= 1'b0;
        end else begin
            cfg_err <= state == IDLE && start && !cfg_ok;
            fcnt    <= (state == FETCH) ? fcnt + 3'd1 : 3'd0;
            if (accept) begin
                dst_w   <= cfg_dst_w;
                dst_h   <= cfg_dst_h;
                x_ratio <= cfg_x_ratio;
                y_ratio <= cfg_y_ratio;
                i       <= '0;
                j       <= '0;
            end
            // Each slot captures the read issued in the previous slot.
            if (state == FETCH && fcnt == 3'd1) p00 <= mem_rd_data;
            if (state == FETCH && fcnt == 3'd2) p10 <= mem_rd_data;
            if (state == FETCH && fcnt == 3'd3) p01 <= mem_rd_data;
            if (state == FETCH && fcnt == 3'd4) p11 <= mem_rd_data;
            if (state == CALC) begin
                out_data <= pix;
                out_x    <= j;
                out_y    <= i;
                out_last <= i == dst_h - DIM_W'(1) && row_end;
            end
            if (hs && !out_last) begin
                j <= row_end ? '0 : j + DIM_W'(1);
                i <= row_end ? i + DIM_W'(1) : i;
            end
        end
    end
endmodule

// File: tb/tb_downscale_bilinear_stream.sv
// tb_downscale_bilinear_stream: directed bench for downscale_bilinear_stream on a 4x4 source frame.
module tb_downscale_bilinear_stream;
    localparam int DW = 3;
    localparam int AW = 4;

    logic          clk = 1'b0, rst_n = 1'b0, start = 1'b0, out_ready = 1'b0;
    logic [DW-1:0] cfg_dst_w = '0, cfg_dst_h = '0;
    logic [15:0]   cfg_x_ratio = '0, cfg_y_ratio = '0;
    logic          mem_rd_en;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_rd_data = '0;
    logic          out_valid, out_last, busy, done, cfg_err;
    logic [7:0]    out_data;
    logic [DW-1:0] out_x, out_y;

    logic [7:0] mem [16];
    int errors = 0, checks = 0;
    int rd_cnt = 0, rd_in_out = 0, rd_base = 0;
    int npix, first_lat, done_cyc, stall_bad, busy1;
    int got_d [32], got_x [32], got_y [32], got_l [32];

    downscale_bilinear_stream #(.SRC_W(4), .SRC_H(4), .PIX_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .cfg_dst_w(cfg_dst_w), .cfg_dst_h(cfg_dst_h),
        .cfg_x_ratio(cfg_x_ratio), .cfg_y_ratio(cfg_y_ratio),
        .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_x(out_x), .out_y(out_y), .out_last(out_last),
        .busy(busy), .done(done), .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    // Frame memory with one cycle read latency, plus read accounting.
    always @(posedge clk) begin
        if (mem_rd_en) begin
            mem_rd_data <= mem[mem_addr];
            rd_cnt <= rd_cnt + 1;
            if (out_valid) rd_in_out <= rd_in_out + 1;
        end
    end

    task automatic load_img(input int kind);
        for (int y = 0; y < 4; y++)
            for (int x = 0; x < 4; x++)
                mem[y*4+x] = kind == 0 ? 8'(10*x + 40*y) : kind == 1 ? 8'(x) :
                             kind == 2 ? 8'd255 : 8'(10*x + 40*y + 5);
    endtask

    // Launches a frame and records the stream; cycle 0 is the start cycle.
    task automatic run_frame(input logic [DW-1:0] dw, input logic [DW-1:0] dh,
                             input logic [15:0] xr, input logic [15:0] yr, input bit bp);
        logic [7:0]    pd;
        logic [DW-1:0] px, py;
        bit            pstall;
        npix = 0; first_lat = -1; done_cyc = -1; stall_bad = 0; busy1 = 0;
        pstall = 0; pd = '0; px = '0; py = '0;
        @(negedge clk);
        cfg_dst_w = dw; cfg_dst_h = dh; cfg_x_ratio = xr; cfg_y_ratio = yr;
        start = 1'b1; out_ready = 1'b0;
        rd_base = rd_cnt;
        for (int cyc = 1; cyc < 1000; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            if (cyc == 1) busy1 = int'(busy);
            if (cyc == 2) begin
                start = 1'b1; cfg_dst_w = 3'd1; cfg_dst_h = 3'd1;
                cfg_x_ratio = 16'h0200; cfg_y_ratio = 16'h0000;
            end
            if (pstall && (!out_valid || out_data !== pd || out_x !== px || out_y !== py))
                stall_bad++;
            if (out_valid && first_lat < 0) first_lat = cyc;
            if (done) begin
                done_cyc = cyc;
                break;
            end
            out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            if (out_valid && out_ready && npix < 32) begin
                got_d[npix] = int'(out_data); got_x[npix] = int'(out_x);
                got_y[npix] = int'(out_y);    got_l[npix] = int'(out_last);
                npix++;
            end
            pstall = out_valid && !out_ready;
            pd = out_data; px = out_x; py = out_y;
        end
        start = 1'b0; out_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; start = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({mem_rd_en, mem_addr, out_valid, out_data, out_x, out_y, out_last, busy, done, cfg_err} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: rd_en=%b addr=%0d valid=%b data=%0d x=%0d y=%0d last=%b busy=%b done=%b cfg_err=%b, all required 0",
                     mem_rd_en, mem_addr, out_valid, out_data, out_x, out_y, out_last, busy, done, cfg_err);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || mem_rd_en !== 1'b0) begin
            errors++;
            $display("FAIL idle_quiet: busy=%b rd_en=%b, required 0 0", busy, mem_rd_en);
        end
    endtask

    task automatic test_downscale;
        load_img(0);
        run_frame(3'd3, 3'd3, 16'h0180, 16'h0180, 1'b0);
        checks++;
        if (npix !== 9) begin errors++; $display("FAIL ds_count: got %0d pixels, expected 9", npix); end
        checks++;
        if (first_lat !== 7) begin errors++; $display("FAIL ds_latency: first valid at %0d, expected 7", first_lat); end
        checks++;
        if (done_cyc !== 64) begin errors++; $display("FAIL ds_done_cycle: done at %0d, expected 64", done_cyc); end
        checks++;
        if (busy1 !== 1) begin errors++; $display("FAIL ds_busy: busy after start %0d, expected 1", busy1); end
        for (int k = 0; k < npix && k < 9; k++) begin
            checks++;
            if (got_d[k] !== 15*(k%3) + 60*(k/3) || got_x[k] !== k%3 || got_y[k] !== k/3 || got_l[k] !== int'(k == 8)) begin
                errors++;
                $display("FAIL ds_pixel%0d: got d=%0d x=%0d y=%0d last=%0d, expected d=%0d x=%0d y=%0d last=%0d",
                         k, got_d[k], got_x[k], got_y[k], got_l[k], 15*(k%3) + 60*(k/3), k%3, k/3, int'(k == 8));
            end
        end
        checks++;
        if (got_d[4] !== 75 || got_d[8] !== 150) begin
            errors++; $display("FAIL ds_corners: (1,1)=%0d (2,2)=%0d, expected 75 150", got_d[4], got_d[8]);
        end
        checks++;
        if (rd_cnt - rd_base !== 36) begin errors++; $display("FAIL ds_reads: %0d reads, expected 36", rd_cnt - rd_base); end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL ds_after_done: done=%b busy=%b, expected 0 0", done, busy);
        end
    endtask

    task automatic test_identity;
        load_img(0);
        run_frame(3'd4, 3'd4, 16'h0100, 16'h0100, 1'b0);
        checks++;
        if (npix !== 16) begin errors++; $display("FAIL id_count: got %0d pixels, expected 16", npix); end
        checks++;
        if (done_cyc !== 113) begin errors++; $display("FAIL id_done_cycle: done at %0d, expected 113", done_cyc); end
        for (int k = 0; k < npix && k < 16; k++) begin
            checks++;
            if (got_d[k] !== 10*(k%4) + 40*(k/4) || got_x[k] !== k%4 || got_y[k] !== k/4 || got_l[k] !== int'(k == 15)) begin
                errors++;
                $display("FAIL id_pixel%0d: got d=%0d x=%0d y=%0d last=%0d, expected d=%0d x=%0d y=%0d last=%0d",
                         k, got_d[k], got_x[k], got_y[k], got_l[k], 10*(k%4) + 40*(k/4), k%4, k/4, int'(k == 15));
            end
        end
    endtask

    task automatic test_round_sat;
        load_img(1);
        run_frame(3'd2, 3'd1, 16'h0080, 16'h0000, 1'b0);
        checks++;
        if (npix !== 2 || got_d[0] !== 0 || got_d[1] !== 1 || got_l[1] !== 1) begin
            errors++;
            $display("FAIL rounding: n=%0d d0=%0d d1=%0d last1=%0d, expected n=2 d0=0 d1=1 last1=1",
                     npix, got_d[0], got_d[1], got_l[1]);
        end
        load_img(2);
        run_frame(3'd2, 3'd2, 16'h0180, 16'h0180, 1'b0);
        checks++;
        if (npix !== 4) begin errors++; $display("FAIL sat_count: got %0d pixels, expected 4", npix); end
        for (int k = 0; k < npix && k < 4; k++) begin
            checks++;
            if (got_d[k] !== 255) begin errors++; $display("FAIL sat_pixel%0d: got %0d, expected 255", k, got_d[k]); end
        end
    endtask

    task automatic test_backpressure;
        load_img(0);
        run_frame(3'd3, 3'd3, 16'h0180, 16'h0180, 1'b1);
        checks++;
        if (npix !== 9) begin errors++; $display("FAIL bp_count: got %0d pixels, expected 9", npix); end
        checks++;
        if (stall_bad !== 0) begin errors++; $display("FAIL bp_stable: %0d unstable stall cycles, expected 0", stall_bad); end
        for (int k = 0; k < npix && k < 9; k++) begin
            checks++;
            if (got_d[k] !== 15*(k%3) + 60*(k/3) || got_x[k] !== k%3 || got_y[k] !== k/3) begin
                errors++;
                $display("FAIL bp_pixel%0d: got d=%0d x=%0d y=%0d, expected d=%0d x=%0d y=%0d",
                         k, got_d[k], got_x[k], got_y[k], 15*(k%3) + 60*(k/3), k%3, k/3);
            end
        end
        checks++;
        if (rd_in_out !== 0) begin errors++; $display("FAIL bp_reads_in_out: %0d reads while valid, expected 0", rd_in_out); end
    endtask

    task automatic test_cfg_err;
        rd_base = rd_cnt;
        for (int t = 0; t < 2; t++) begin
            @(negedge clk);
            cfg_dst_w = (t == 0) ? 3'd0 : 3'd3;
            cfg_dst_h = (t == 0) ? 3'd3 : 3'd5;
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            checks++;
            if (cfg_err !== 1'b1 || busy !== 1'b0) begin
                errors++; $display("FAIL cfg_err_pulse%0d: cfg_err=%b busy=%b, expected 1 0", t, cfg_err, busy);
            end
            @(negedge clk);
            checks++;
            if (cfg_err !== 1'b0 || busy !== 1'b0) begin
                errors++; $display("FAIL cfg_err_clear%0d: cfg_err=%b busy=%b, expected 0 0", t, cfg_err, busy);
            end
        end
        checks++;
        if (rd_cnt - rd_base !== 0) begin errors++; $display("FAIL cfg_err_reads: %0d reads, expected 0", rd_cnt - rd_base); end
        load_img(3);
        run_frame(3'd1, 3'd1, 16'h0000, 16'h0000, 1'b0);
        checks++;
        if (npix !== 1 || got_d[0] !== 5 || got_l[0] !== 1 || done_cyc !== 8) begin
            errors++;
            $display("FAIL one_pixel: n=%0d d=%0d last=%0d done_at=%0d, expected n=1 d=5 last=1 done_at=8",
                     npix, got_d[0], got_l[0], done_cyc);
        end
    endtask

    task automatic test_reset_mid;
        int quiet_bad;
        load_img(0);
        @(negedge clk);
        cfg_dst_w = 3'd3; cfg_dst_h = 3'd3; cfg_x_ratio = 16'h0180; cfg_y_ratio = 16'h0180;
        start = 1'b1; out_ready = 1'b1;
        repeat (24) begin
            @(negedge clk);
            start = 1'b0;
        end
        checks++;
        if (mem_rd_en !== 1'b1 || busy !== 1'b1) begin
            errors++; $display("FAIL mid_fetch: rd_en=%b busy=%b, expected 1 1 in 4th pixel fetch", mem_rd_en, busy);
        end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checks++;
        if ({mem_rd_en, mem_addr, out_valid, out_data, out_x, out_y, out_last, busy, done, cfg_err} !== '0) begin
            errors++;
            $display("FAIL mid_reset_outputs: rd_en=%b addr=%0d valid=%b data=%0d x=%0d y=%0d last=%b busy=%b done=%b cfg_err=%b, all required 0",
                     mem_rd_en, mem_addr, out_valid, out_data, out_x, out_y, out_last, busy, done, cfg_err);
        end
        rd_base = rd_cnt;
        quiet_bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (done || out_valid || busy) quiet_bad++;
        end
        checks++;
        if (quiet_bad !== 0 || rd_cnt - rd_base !== 0) begin
            errors++; $display("FAIL mid_quiet: %0d active cycles, %0d reads, expected 0 0", quiet_bad, rd_cnt - rd_base);
        end
        out_ready = 1'b0;
        run_frame(3'd3, 3'd3, 16'h0180, 16'h0180, 1'b0);
        checks++;
        if (npix !== 9 || done_cyc !== 64) begin
            errors++; $display("FAIL mid_rerun: n=%0d done_at=%0d, expected 9 64", npix, done_cyc);
        end
        for (int k = 0; k < npix && k < 9; k++) begin
            checks++;
            if (got_d[k] !== 15*(k%3) + 60*(k/3) || got_l[k] !== int'(k == 8)) begin
                errors++;
                $display("FAIL mid_pixel%0d: got d=%0d last=%0d, expected d=%0d last=%0d",
                         k, got_d[k], got_l[k], 15*(k%3) + 60*(k/3), int'(k == 8));
            end
        end
    endtask

    initial begin
        test_reset;
        test_downscale;
        test_identity;
        test_round_sat;
        test_backpressure;
        test_cfg_err;
        test_reset_mid;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/downscale_bilinear_stream.md
# downscale_bilinear_stream

Parametrised successor to the fixed-size bilinear downscaler: shrinks a SRC_H×SRC_W greyscale frame to a runtime-selected destination size using Q8.8 bilinear interpolation. Source pixels come from a 1-cycle-latency frame memory port instead of a flat array input. Results leave as a valid/ready pixel stream with coordinates and a last flag. It sits between the frame buffer and the display/writeback path.

## Interface
- SRC_W, 640: source width in pixels (≥2)
- SRC_H, 480: source height in pixels (≥2)
- PIX_W, 8: pixel width in bits
- DIM_W, $clog2(max(SRC_W,SRC_H))+1: width of dimension/coordinate fields
- ADDR_W, $clog2(SRC_W*SRC_H): frame memory address width
- Clock and reset: single clock `clk`; reset `rst_n` is synchronous, active-low.
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- start  in  1  begin a frame; sampled only in IDLE
- cfg_dst_w  in  DIM_W  destination width, latched on accepted start
- cfg_dst_h  in  DIM_W  destination height, latched on accepted start
- cfg_x_ratio  in  16  horizontal step, Q8.8, latched on accepted start
- cfg_y_ratio  in  16  vertical step, Q8.8, latched on accepted start
- mem_rd_en  out  1  read strobe
- mem_addr  out  ADDR_W  read address = y*SRC_W + x
- mem_rd_data  in  PIX_W  read data, valid exactly one cycle after mem_rd_en
- out_valid  out  1  output pixel valid
- out_ready  in  1  downstream accepts
- out_data  out  PIX_W  interpolated pixel
- out_x, out_y  out  DIM_W each  destination coordinate of out_data
- out_last  out  1  marks the final pixel of the frame
- busy  out  1  high from accepted start until DONE exits
- done  out  1  one-cycle pulse after the last pixel handshake
- cfg_err  out  1  one-cycle pulse on a rejected start

## Operation
- States: IDLE → FETCH → CALC → OUT → (FETCH | DONE) → IDLE.
- IDLE: if start, validate config. Config is invalid when dst_w = 0, dst_h = 0, dst_w > SRC_W or dst_h > SRC_H. Invalid config: pulse cfg_err next cycle and stay in IDLE. Valid config: latch config, set i=j=0, go to FETCH.
- Coordinates per pixel (i=row, j=col):
  - x_fp = j*x_ratio, full 32-bit product
  - x_l = x_fp>>8; alpha = x_fp[7:0]
  - If x_l ≥ SRC_W-1: x_l = SRC_W-1, alpha = 0
  - x_h = min(x_l+1, SRC_W-1)
  - y_l, y_h and beta are computed the same way from i, y_ratio and SRC_H.
- FETCH: issue 4 reads on consecutive cycles, in the order I00(y_l,x_l), I10(y_l,x_h), I01(y_h,x_l), I11(y_h,x_h). Capture each read one cycle later. Leave FETCH the cycle after the 4th capture is registered (5 cycles in total).
- CALC, one cycle:
  - top = I00*(256-alpha) + I10*alpha
  - bot = I01*(256-alpha) + I11*alpha
  - sum = top*(256-beta) + bot*beta, on PIX_W+18 bits
  - pix = (sum + 2^15) >> 16, saturated to 2^PIX_W-1
  - Register out_data, out_x = j, out_y = i, and out_last = (i=dst_h-1 && j=dst_w-1).
- OUT: out_valid = 1, and out_data, out_x, out_y, out_last hold stable until out_ready. On the handshake:
  - If last: go to DONE.
  - Else: advance in raster order (j++; on wrap j=0, i++) and go to FETCH.
- DONE: done = 1 for one cycle, busy drops, go to IDLE.
- start while busy is ignored. A config change while busy has no effect.
- The block never drives mem_rd_en outside FETCH.

## Timing
- Reset (rst_n=0 at posedge): state = IDLE. All outputs are 0: mem_rd_en, mem_addr, out_valid, out_data, out_x, out_y, out_last, busy, done, cfg_err. Internal counters are cleared.
- Reset mid-frame aborts immediately. No further reads or outputs occur, and done is not pulsed.
- Latency from start to first out_valid = 7 cycles: 1 (IDLE accept) + 5 (FETCH) + 1 (CALC).
- With out_ready held high, each pixel takes 7 cycles (FETCH 5 + CALC 1 + OUT 1). A frame takes 7·W·H + 1 cycles to done.
- Backpressure: each cycle of out_ready=0 in OUT adds exactly one cycle. Fetching of the next pixel does not begin until the handshake.
- busy is 1 from the cycle after an accepted start through the DONE cycle. A new start can be accepted the cycle after DONE.

## Test plan
- SRC 4×4, img[y][x] = 10x + 40y, dst 3×3, ratios 0x0180 → 9 pixels 15j + 60i in raster order: (1,1)=75, (2,2)=150. out_last only on (2,2), done 1 cycle after its handshake, first out_valid 7 cycles after start.
- Identity: dst = SRC 4×4, ratios 0x0100 → output equals input exactly. The I10/I11 reads at the right edge are clamped to x = 3.
- Rounding: I00=0, I10=1, I01=0, I11=1, alpha=0x80, beta=0 → pix = 1 (0.5 rounds up). Saturation: all neighbours 255 → 255.
- Backpressure: out_ready toggles 1/0 randomly → out_data, out_x, out_y stable while stalled, no pixel lost or duplicated, no mem_rd_en while in OUT.
- Config errors: start with dst_w=0, then dst_h=5 on a 4×4 source → cfg_err pulse for each, busy stays 0, no memory reads. Dst 1×1 with ratio 0 → one pixel = img[0][0], out_last=1.
- Reset mid-frame: assert rst_n=0 during the 4th pixel's FETCH → all outputs 0 next cycle, no done pulse. A subsequent start runs a full frame correctly.
